// File: rtl/reg_write_arbiter_pkg.sv
// ============================================================================
// Module      : reg_write_arbiter_pkg
// Description : Shared types, default constants and round-robin pick helper
//               for the shared-register write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_write_arbiter_pkg;

    localparam int c_DEF_NUM_REQ = 4;
    localparam int c_DEF_DATA_W  = 8;
    localparam int c_MAX_REQ     = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // First set bit at or above ptr, wrapping modulo n; 0 when req is empty.
    function automatic logic [3:0] rr_pick_fn(input logic [15:0] req,
                                              input logic [3:0]  ptr,
                                              input int          n);
        logic [3:0] idx;
        logic       found;
        int         j;
        idx   = 4'd0;
        found = 1'b0;
        for (int k = 0; k < c_MAX_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if ((k < n) && !found && req[j[3:0]]) begin
                idx   = j[3:0];
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
// ============================================================================
// Module      : reg_write_arbiter_rr_pick
// Description : Combinational round-robin priority selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_write_arbiter_rr_pick
    import reg_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = c_DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    logic [15:0] w_req_ext;
    logic [3:0]  w_ptr_ext;
    logic [3:0]  w_idx_full;

    assign w_req_ext  = 16'(req);
    assign w_ptr_ext  = 4'(ptr);
    assign w_idx_full = rr_pick_fn(w_req_ext, w_ptr_ext, NUM_REQ);
    assign valid      = |req;
    assign idx        = w_idx_full[IDX_W-1:0];

endmodule

`default_nettype wire

// File: rtl/reg_write_arbiter.sv
// ============================================================================
// Module      : reg_write_arbiter
// Description : Round-robin write arbiter owning one shared DATA_W register.
//               Optional synchronous clear via REG_WRITE_ARBITER_CLEAR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ = c_DEF_NUM_REQ,
    parameter int DATA_W  = c_DEF_DATA_W,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef REG_WRITE_ARBITER_CLEAR_EN
    input  logic                      clear,
`endif
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        lock,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        grant,
    output logic [IDX_W-1:0]          owner,
    output logic                      busy,
    output logic [DATA_W-1:0]         q
);

    state_t               r_state, w_state;
    logic [NUM_REQ-1:0]   r_grant, w_grant;
    logic [IDX_W-1:0]     r_owner, w_owner;
    logic [IDX_W-1:0]     r_ptr,   w_ptr;
    logic [DATA_W-1:0]    r_q,     w_q;
    logic                 w_pick_valid;
    logic [IDX_W-1:0]     w_pick_idx;
    logic [DATA_W-1:0]    w_lane [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign w_lane[gi] = wdata[gi*DATA_W +: DATA_W];
    end

    reg_write_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_q     <= '0;
        end else begin
            r_state <= w_state;
            r_grant <= w_grant;
            r_owner <= w_owner;
            r_ptr   <= w_ptr;
            r_q     <= w_q;
        end
    end

    always_comb begin
        w_state = r_state;
        w_grant = r_grant;
        w_owner = r_owner;
        w_ptr   = r_ptr;
        w_q     = r_q;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_grant             = '0;
                    w_grant[w_pick_idx] = 1'b1;
                    w_owner             = w_pick_idx;
                    w_state             = BUSY;
                end
            end
            BUSY: begin
                // The grant is committed: the write happens even if req dropped.
                w_q = w_lane[r_owner];
                if (!(lock[r_owner] && req[r_owner])) begin
                    w_grant = '0;
                    w_ptr   = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0
                                                               : r_owner + IDX_W'(1);
                    w_state = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
`ifdef REG_WRITE_ARBITER_CLEAR_EN
        if (clear) w_q = '0;
`endif
    end

    assign grant = r_grant;
    assign owner = r_owner;
    assign busy  = (r_state == BUSY);
    assign q     = r_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
// ============================================================================
// Module      : tb_reg_write_arbiter
// Description : Self-checking bench for reg_write_arbiter with a behavioural
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           clear;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   grant;
    logic [1:0]     owner;
    logic           busy;
    logic [W-1:0]   q;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    bit           m_busy;
    logic [N-1:0] m_grant;
    int           m_owner;
    int           m_ptr;
    logic [W-1:0] m_q;

    always #5 clk = ~clk;

    reg_write_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk   (clk),
        .reset (reset),
`ifdef REG_WRITE_ARBITER_CLEAR_EN
        .clear (clear),
`endif
        .req   (req),
        .lock  (lock),
        .wdata (wdata),
        .grant (grant),
        .owner (owner),
        .busy  (busy),
        .q     (q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit clr;
        clr = 1'b0;
`ifdef REG_WRITE_ARBITER_CLEAR_EN
        clr = clear;
`endif
        if (reset) begin
            m_busy = 0; m_grant = '0; m_owner = 0; m_ptr = 0; m_q = '0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!m_busy && req[c]) begin
                    m_busy = 1; m_owner = c; m_grant = N'(1) << c;
                end
            end
        end else begin
            m_q = wdata[m_owner*W +: W];
            if (!(lock[m_owner] && req[m_owner])) begin
                m_busy = 0; m_grant = '0; m_ptr = (m_owner + 1) % N;
            end
        end
        if (clr && !reset) m_q = '0;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("grant", 32'(grant), 32'(m_grant));
        chk("owner", 32'(owner), 32'(m_owner));
        chk("busy",  32'(busy),  32'(m_busy));
        chk("q",     32'(q),     32'(m_q));
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; req = '0; lock = '0; wdata = '0;
        m_busy = 0; m_grant = '0; m_owner = 0; m_ptr = 0; m_q = '0;
        step(); step();
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_grant", 32'(grant), 32'h0);
        reset = 1'b0;

        // Idle with no requests
        for (int i = 0; i < 5; i++) step();

        // All four requesting: grants rotate 0,1,2,3,0
        req = 4'b1111; wdata = 32'h44332211;
        for (int i = 0; i < 8; i++) step();
        chk("rr_q_last", 32'(q), 32'h44);
        step();
        chk("rr_wrap_grant", 32'(grant), 32'b0001);
        req = '0; step();

        // Locked ownership by requester 2 for four writes
        req = 4'b0100; lock = 4'b0100; step();
        chk("lock_grant", 32'(grant), 32'b0100);
        for (int i = 0; i < 4; i++) begin
            wdata[2*W +: W] = W'(5 + i);
            if (i == 3) lock = '0;
            step();
            if (i < 3) chk("lock_hold", 32'(grant), 32'b0100);
        end
        chk("lock_q", 32'(q), 32'h08);
        req = '0; step();

        // Requester 1 drops req in its grant cycle; write still commits
        req = 4'b0010; step();
        chk("drop_grant", 32'(grant), 32'b0010);
        req = '0; wdata[1*W +: W] = 8'hA5; step();
        chk("drop_q", 32'(q), 32'hA5);

        // Reset during locked BUSY
        req = 4'b0001; lock = 4'b0001; wdata[0 +: W] = 8'h5A; step(); step();
        reset = 1'b1; step();
        chk("rst_busy_q", 32'(q), 32'h0);
        chk("rst_busy_busy", 32'(busy), 32'h0);
        reset = 1'b0; lock = '0; step();
        chk("post_rst_grant", 32'(grant), 32'b0001);
        req = '0; step();

`ifdef REG_WRITE_ARBITER_CLEAR_EN
        req = 4'b1000; step();
        clear = 1'b1; wdata[3*W +: W] = 8'h3C; step();
        chk("clear_q", 32'(q), 32'h0);
        chk("clear_grant", 32'(grant), 32'h0);
        clear = 1'b0; req = '0; step();
`endif

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            req   = N'($urandom);
            lock  = N'($urandom);
            wdata = $urandom;
            reset = ($urandom_range(0, 63) == 0);
`ifdef REG_WRITE_ARBITER_CLEAR_EN
            clear = ($urandom_range(0, 15) == 0);
`endif
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
